// File: rtl/map_pkg.sv
// map_pkg
//   Shared constants and types for the tile map write path.
//   The map is MAP_W x MAP_H tiles. Readback scales it by MAP_SCALE to 640x480.
package map_pkg;

   localparam int MAP_W     = 128;
   localparam int MAP_H     = 96;
   localparam int MAP_SCALE = 5;
   localparam int MAP_DEPTH = MAP_W * MAP_H;

   typedef logic [7:0]  tile_coord_t;
   typedef logic [23:0] rgb_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      FINISH
   } wr_state_t;

endpackage

// File: rtl/map_raster_counter.sv
// map_raster_counter
//   Column/row walker for one clipped rectangle. Coordinates run in raster order.
//   Ports:
//     clk_i, rst_i       clock, asynchronous active-high reset
//     load_i             take the origin and clipped bounds
//     step_i             advance to the next tile
//     x_first_i/y_first_i, x_last_i/y_last_i   rectangle bounds (inclusive)
//     next_col_o/next_row_o   tile that follows the current one
//     last_o             current tile is (x_last, y_last)
module map_raster_counter
   import map_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        load_i,
   input  logic        step_i,
   input  tile_coord_t x_first_i,
   input  tile_coord_t y_first_i,
   input  tile_coord_t x_last_i,
   input  tile_coord_t y_last_i,
   output tile_coord_t next_col_o,
   output tile_coord_t next_row_o,
   output logic        last_o
);

   tile_coord_t col_q, row_q;
   tile_coord_t x_first_q, x_last_q, y_last_q;
   tile_coord_t col_d, row_d;
   logic        col_end;

   // Wrapping the column and bumping the row happen in the same step.
   always_comb begin
      col_end = (col_q == x_last_q);
      if (col_end) begin
         col_d = x_first_q;
         row_d = row_q + 8'd1;
      end else begin
         col_d = col_q + 8'd1;
         row_d = row_q;
      end
   end

   assign last_o     = col_end && (row_q == y_last_q);
   assign next_col_o = col_d;
   assign next_row_o = row_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         col_q     <= '0;
         row_q     <= '0;
         x_first_q <= '0;
         x_last_q  <= '0;
         y_last_q  <= '0;
      end else if (load_i) begin
         col_q     <= x_first_i;
         row_q     <= y_first_i;
         x_first_q <= x_first_i;
         x_last_q  <= x_last_i;
         y_last_q  <= y_last_i;
      end else if (step_i) begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/map_rect_writer.sv
// map_rect_writer
//   Paints one clipped rectangle of a single colour into the tile map RAM,
//   one write per clock, then pulses done.
//   Ports:
//     Clk, Reset                  clock, asynchronous active-high reset
//     cmd_valid / cmd_ready       command handshake
//     cmd_x, cmd_y, cmd_w, cmd_h  rectangle origin and size in tiles
//     cmd_color                   fill colour (RGB888)
//     write_address, data_In, we  map RAM write port
//     busy                        command in progress
//     done                        one-cycle completion pulse
//
//   state  | meaning
//   IDLE   | ready for a command
//   FILL   | one map write per cycle; outputs hold the tile being written
//   FINISH | done pulse; entered straight from IDLE it waits one cycle first
module map_rect_writer #(
   parameter int MAP_W  = map_pkg::MAP_W,
   parameter int MAP_H  = map_pkg::MAP_H,
   parameter int ADDR_W = 19,
   parameter int DATA_W = 24
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [7:0]             cmd_x,
   input  logic [7:0]             cmd_y,
   input  logic [7:0]             cmd_w,
   input  logic [7:0]             cmd_h,
   input  logic [DATA_W-1:0]      cmd_color,
   output logic [ADDR_W-1:0]      write_address,
   output logic [DATA_W-1:0]      data_In,
   output logic                   we,
   output logic                   busy,
   output logic                   done
);

   import map_pkg::*;

   localparam logic [8:0] MAP_W9 = 9'(MAP_W);
   localparam logic [8:0] MAP_H9 = 9'(MAP_H);

   wr_state_t           state_q;
   logic                cmd_ready_q, busy_q, done_q, we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;

   logic [8:0]          x_end_d, y_end_d;
   tile_coord_t         x_last_d, y_last_d;
   logic                cmd_empty_d;
   logic                accept;
   tile_coord_t         next_col, next_row;
   logic                last_tile;

   function automatic logic [ADDR_W-1:0] tile_addr(input tile_coord_t row, input tile_coord_t col);
      return ADDR_W'(row) * ADDR_W'(MAP_W) + ADDR_W'(col);
   endfunction

   // Clip in 9 bits so x+w up to 510 cannot wrap.
   always_comb begin
      x_end_d     = {1'b0, cmd_x} + {1'b0, cmd_w};
      y_end_d     = {1'b0, cmd_y} + {1'b0, cmd_h};
      x_last_d    = (x_end_d > MAP_W9) ? 8'(MAP_W9 - 9'd1) : 8'(x_end_d - 9'd1);
      y_last_d    = (y_end_d > MAP_H9) ? 8'(MAP_H9 - 9'd1) : 8'(y_end_d - 9'd1);
      cmd_empty_d = (cmd_w == 8'd0) || (cmd_h == 8'd0) ||
                    ({1'b0, cmd_x} >= MAP_W9) || ({1'b0, cmd_y} >= MAP_H9);
   end

   assign accept = (state_q == IDLE) && cmd_valid && cmd_ready_q;

   map_raster_counter u_raster (
      .clk_i      (Clk),
      .rst_i      (Reset),
      .load_i     (accept && !cmd_empty_d),
      .step_i     ((state_q == FILL) && !last_tile),
      .x_first_i  (cmd_x),
      .y_first_i  (cmd_y),
      .x_last_i   (x_last_d),
      .y_last_i   (y_last_d),
      .next_col_o (next_col),
      .next_row_o (next_row),
      .last_o     (last_tile)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         data_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               we_q   <= 1'b0;
               if (accept) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  data_q      <= cmd_color;
                  if (cmd_empty_d) begin
                     state_q <= FINISH;
                  end else begin
                     // The origin tile is written in the very next cycle.
                     state_q <= FILL;
                     we_q    <= 1'b1;
                     addr_q  <= tile_addr(cmd_y, cmd_x);
                  end
               end
            end
            FILL: begin
               if (last_tile) begin
                  state_q <= FINISH;
                  we_q    <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  addr_q <= tile_addr(next_row, next_col);
               end
            end
            FINISH: begin
               if (done_q) begin
                  done_q      <= 1'b0;
                  busy_q      <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  // Empty command: no writes, done one cycle later than entry.
                  done_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign we            = we_q;
   assign write_address = addr_q;
   assign data_In       = data_q;

endmodule

// File: tb/tb_map_rect_writer.sv
module tb_map_rect_writer;

   logic        Clk;
   logic        Reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h;
   logic [23:0] cmd_color;
   logic [18:0] write_address;
   logic [23:0] data_In;
   logic        we, busy, done;

   int tests = 0;
   int fails = 0;

   map_rect_writer dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_x         (cmd_x),
      .cmd_y         (cmd_y),
      .cmd_w         (cmd_w),
      .cmd_h         (cmd_h),
      .cmd_color     (cmd_color),
      .write_address (write_address),
      .data_In       (data_In),
      .we            (we),
      .busy          (busy),
      .done          (done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      int          x, y, w, h;
      logic [23:0] color;
      int          nw;      // expected write count
      int          first;   // expected first address
      int          last;    // expected last address
      int          xl, yl;  // expected clipped last column/row
      int          lat;     // cycles from acceptance edge to done
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int k, nw, bad, done_at, first_a, prev_a, a, col, row;
      @(negedge Clk);
      check($sformatf("v%0d_idle_ready", idx), int'(cmd_ready), 1);
      cmd_x = 8'(v.x); cmd_y = 8'(v.y); cmd_w = 8'(v.w); cmd_h = 8'(v.h);
      cmd_color = v.color;
      cmd_valid = 1'b1;
      k = 0; nw = 0; bad = 0; done_at = -1; first_a = -1; prev_a = -1;
      while (done_at < 0 && k < v.lat + 20) begin
         @(negedge Clk);
         k++;
         if (k == 1) cmd_valid = 1'b0;
         if (!busy) bad++;
         if (cmd_ready) bad++;
         if (we) begin
            a = int'(write_address);
            nw++;
            if (nw == 1) first_a = a;
            else if (a <= prev_a) bad++;
            if (a > 12287) bad++;
            col = a % 128;
            row = a / 128;
            if (col < v.x || col > v.xl || row < v.y || row > v.yl) bad++;
            if (data_In != v.color) bad++;
            prev_a = a;
         end
         if (done) begin
            done_at = k;
            if (we) bad++;
         end
      end
      check($sformatf("v%0d_done_cycle", idx), done_at, v.lat);
      check($sformatf("v%0d_writes", idx), nw, v.nw);
      if (v.nw > 0) begin
         check($sformatf("v%0d_first_addr", idx), first_a, v.first);
         check($sformatf("v%0d_last_addr", idx), prev_a, v.last);
      end
      check($sformatf("v%0d_bad_cycles", idx), bad, 0);
      @(negedge Clk);
      check($sformatf("v%0d_ready_after", idx), int'(cmd_ready), 1);
      check($sformatf("v%0d_busy_after", idx), int'(busy), 0);
      check($sformatf("v%0d_done_once", idx), int'(done), 0);
      check($sformatf("v%0d_we_after", idx), int'(we), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ea[5];
      logic [23:0] ec[5];
      int nwr, bad, ndone, acc_k, b_first_k, quiet_we;

      vecs[0] = '{x:10,  y:5,  w:2,   h:2,  color:24'hFF0000, nw:4,     first:650,   last:779,   xl:11,  yl:6,  lat:5};
      vecs[1] = '{x:126, y:95, w:4,   h:3,  color:24'h123456, nw:2,     first:12286, last:12287, xl:127, yl:95, lat:3};
      vecs[2] = '{x:0,   y:0,  w:0,   h:5,  color:24'h111111, nw:0,     first:0,     last:0,     xl:0,   yl:0,  lat:2};
      vecs[3] = '{x:200, y:0,  w:1,   h:1,  color:24'h222222, nw:0,     first:0,     last:0,     xl:0,   yl:0,  lat:2};
      vecs[4] = '{x:0,   y:0,  w:128, h:96, color:24'h00FF00, nw:12288, first:0,     last:12287, xl:127, yl:95, lat:12289};
      vecs[5] = '{x:127, y:0,  w:1,   h:3,  color:24'h0000FF, nw:3,     first:127,   last:383,   xl:127, yl:2,  lat:4};
      vecs[6] = '{x:5,   y:94, w:3,   h:5,  color:24'hABCDEF, nw:6,     first:12037, last:12167, xl:7,   yl:95, lat:7};
      vecs[7] = '{x:0,   y:96, w:1,   h:1,  color:24'h333333, nw:0,     first:0,     last:0,     xl:0,   yl:0,  lat:2};
      vecs[8] = '{x:3,   y:2,  w:255, h:1,  color:24'h445566, nw:125,   first:259,   last:383,   xl:127, yl:2,  lat:126};

      Reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
      #3;
      check("rst_ready", int'(cmd_ready), 1);
      check("rst_we", int'(we), 0);
      check("rst_addr", int'(write_address), 0);
      check("rst_data", int'(data_In), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Second command held on cmd_valid during a fill.
      ea = '{650, 651, 778, 779, 148};
      ec = '{24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000, 24'h00AA00};
      @(negedge Clk);
      cmd_x = 8'd10; cmd_y = 8'd5; cmd_w = 8'd2; cmd_h = 8'd2; cmd_color = 24'hFF0000;
      cmd_valid = 1'b1;
      nwr = 0; bad = 0; ndone = 0; acc_k = -1; b_first_k = -1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge Clk);
         if (k == 1) begin
            cmd_x = 8'd20; cmd_y = 8'd1; cmd_w = 8'd1; cmd_h = 8'd1; cmd_color = 24'h00AA00;
         end
         if (we) begin
            if (nwr < 5) begin
               if (int'(write_address) != ea[nwr] || data_In != ec[nwr]) bad++;
            end else bad++;
            if (int'(write_address) == 148 && b_first_k < 0) begin
               b_first_k = k;
               cmd_valid = 1'b0;
            end
            nwr++;
         end
         if (done) ndone++;
         if (cmd_ready && cmd_valid && acc_k < 0) acc_k = k;
      end
      cmd_valid = 1'b0;
      check("busy_ign_accept_cycle", acc_k, 6);
      check("busy_ign_b_first_write", b_first_k, 7);
      check("busy_ign_writes", nwr, 5);
      check("busy_ign_seq_errors", bad, 0);
      check("busy_ign_done_count", ndone, 2);

      // Reset in the middle of a 4x4 fill.
      @(negedge Clk);
      cmd_x = 8'd4; cmd_y = 8'd4; cmd_w = 8'd4; cmd_h = 8'd4; cmd_color = 24'h5A5A5A;
      cmd_valid = 1'b1;
      @(negedge Clk);
      cmd_valid = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("midrst_write3_we", int'(we), 1);
      check("midrst_write3_addr", int'(write_address), 518);
      #2 Reset = 1'b1;
      #1;
      check("midrst_we", int'(we), 0);
      check("midrst_ready", int'(cmd_ready), 1);
      check("midrst_busy", int'(busy), 0);
      check("midrst_done", int'(done), 0);
      check("midrst_addr", int'(write_address), 0);
      check("midrst_data", int'(data_In), 0);
      @(negedge Clk);
      Reset = 1'b0;
      quiet_we = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         if (we || busy || done) quiet_we++;
      end
      check("midrst_quiet_after", quiet_we, 0);
      run_vec(vecs[0], 9);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/map_rect_writer.md
Name: map_rect_writer

Overview:
- Write-side master for the 128x96 tile map RAM. The map RAM is read back upscaled by 5 to 640x480.
- Accepts one rectangle-fill command: origin, size and 24-bit colour, in map-tile coordinates.
- Emits one map write per clock (address, data, we) until the clipped rectangle is painted, then pulses done.
- Used by game logic to paint tower footprints and path tiles into the map at runtime.

Parameters:
- MAP_W, 128, map width in tiles.
- MAP_H, 96, map height in tiles.
- ADDR_W, 19, write address width; matches the map RAM write port.
- DATA_W, 24, pixel colour width (RGB888).

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  8  rectangle left column, in tiles.
- cmd_y  in  8  rectangle top row, in tiles.
- cmd_w  in  8  rectangle width, in tiles.
- cmd_h  in  8  rectangle height, in tiles.
- cmd_color  in  DATA_W  fill colour.
- write_address  out  ADDR_W  map RAM write address, row*MAP_W + col.
- data_In  out  DATA_W  map RAM write data.
- we  out  1  map RAM write enable.
- busy  out  1  high from acceptance until done.
- done  out  1  one-cycle pulse when the command completes.

Behaviour:
- All outputs are registered. Reset values: cmd_ready=1, we=0, write_address=0, data_In=0, busy=0, done=0, FSM=IDLE. Reset takes effect immediately, including mid-fill; no further writes occur after it.
- FSM states: IDLE, FILL, FINISH.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid && cmd_ready, latch all command fields; cmd_ready drops and busy rises the next cycle.
  - Empty command (cmd_w==0, cmd_h==0, cmd_x>=MAP_W or cmd_y>=MAP_H): go to FINISH with zero writes.
  - Otherwise go to FILL.
- Clipping, computed at acceptance with 9-bit arithmetic:
  - x_last = min(cmd_x+cmd_w, MAP_W) - 1.
  - y_last = min(cmd_y+cmd_h, MAP_H) - 1.
  - Tiles outside the map are never written.
- FILL:
  - One write per cycle, raster order: columns cmd_x..x_last within a row, then rows cmd_y..y_last.
  - Each write cycle: we=1, write_address = row*MAP_W + col, zero-extended to ADDR_W; data_In = latched colour.
  - First write is the cycle after acceptance. Total writes = (x_last-cmd_x+1)*(y_last-cmd_y+1).
  - Column wraps to cmd_x when col==x_last, and row increments in that same step.
  - After the write at (x_last, y_last), go to FINISH.
- FINISH: we=0, done=1 for exactly one cycle, busy=0 and cmd_ready=1 the following cycle, return to IDLE.
- cmd_valid while busy is ignored. Commands are not queued; the caller must hold cmd_valid until it sees cmd_ready.
- Highest address ever emitted: MAP_W*MAP_H-1 = 12287.
- No stalls: the map RAM write port always accepts.

Decomposition:
- Shared package map_pkg holds:
  - constants MAP_W, MAP_H, MAP_SCALE=5, MAP_DEPTH=MAP_W*MAP_H;
  - typedef tile_coord_t (logic [7:0]);
  - typedef rgb_t (logic [23:0]);
  - enum wr_state_t {IDLE, FILL, FINISH}.
- One natural sub-module, map_raster_counter: the column/row counter with wrap and last-tile flag. The top level owns the FSM, clipping and output registers.

Test Plan:
- Basic fill: cmd (x=10, y=5, w=2, h=2, color=FF0000) -> we high 4 cycles, addresses 650, 651, 778, 779, data FF0000; done pulses the cycle after 779; cmd_ready=1 the cycle after that.
- Corner clip: cmd (126, 95, 4, 3) -> exactly 2 writes, addresses 12286, 12287, then done; no address >12287.
- Empty command: cmd (0, 0, 0, 5) -> no we; done 2 cycles after acceptance. Repeat with cmd (200, 0, 1, 1) -> same result.
- Full map: cmd (0, 0, 128, 96, 00FF00) -> 12288 consecutive writes, 0 to 12287 strictly incrementing; busy high throughout; done once.
- Busy ignore: cmd_valid held with a second command during an active fill -> the second command is accepted only when cmd_ready returns, with its first write the next cycle; no write interleaving.
- Reset mid-fill: assert Reset at write 3 of a 4x4 fill -> we drops asynchronously; all outputs reach reset values; the next command executes normally from its origin.
